// File: rtl/bus_arbiter_if.sv
// Signal bundle between the two bus masters, the arbiter and the downstream bus master port.
// The arbiter uses the slave modport; a master-side driver (e.g. a bench) uses the master modport.
interface bus_arbiter_if #(
    parameter int unsigned WORDSIZE = 16,
    parameter int unsigned ADDRSIZE = 16
);
    logic [WORDSIZE-1:0] m0_data_i;
    logic [WORDSIZE-1:0] m1_data_i;
    logic [ADDRSIZE-1:0] m0_addr_i;
    logic [ADDRSIZE-1:0] m1_addr_i;
    logic                m0_we_i;
    logic                m1_we_i;
    logic                m0_hello_i;
    logic                m1_hello_i;
    logic [WORDSIZE-1:0] m0_data_o;
    logic [WORDSIZE-1:0] m1_data_o;
    logic                m0_ack_o;
    logic                m1_ack_o;
    logic                m0_err_o;
    logic                m1_err_o;
    logic [WORDSIZE-1:0] b_data_o;
    logic [ADDRSIZE-1:0] b_addr_o;
    logic                b_we_o;
    logic                b_hello_o;
    logic [WORDSIZE-1:0] b_data_i;
    logic                b_ack_i;

    modport slave (
        input  m0_data_i, m1_data_i, m0_addr_i, m1_addr_i, m0_we_i, m1_we_i,
        input  m0_hello_i, m1_hello_i, b_data_i, b_ack_i,
        output m0_data_o, m1_data_o, m0_ack_o, m1_ack_o, m0_err_o, m1_err_o,
        output b_data_o, b_addr_o, b_we_o, b_hello_o
    );

    modport master (
        output m0_data_i, m1_data_i, m0_addr_i, m1_addr_i, m0_we_i, m1_we_i,
        output m0_hello_i, m1_hello_i, b_data_i, b_ack_i,
        input  m0_data_o, m1_data_o, m0_ack_o, m1_ack_o, m0_err_o, m1_err_o,
        input  b_data_o, b_addr_o, b_we_o, b_hello_o
    );
endinterface

// File: rtl/bus_arbiter.sv
// Two-master round-robin arbiter in front of the bus decoder, one grant per transaction,
// with a watchdog that error-acks transactions the slave never acknowledges.
module bus_arbiter #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 5
) (
    input logic         clk,
    input logic         rst,
    bus_arbiter_if.slave bif
);
    typedef enum logic {StIdle, StBusy} st_t;

    st_t              st_q, st_d;
    logic             gnt_q, gnt_d;
    logic             prio_q, prio_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic cur_hello;
    logic done_ack;
    logic done_err;
    logic timeout;

    assign cur_hello = gnt_q ? bif.m1_hello_i : bif.m0_hello_i;
    assign timeout   = (cnt_q == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q   <= StIdle;
            gnt_q  <= 1'b0;
            prio_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            st_q   <= st_d;
            gnt_q  <= gnt_d;
            prio_q <= prio_d;
            cnt_q  <= cnt_d;
        end
    end

    always_comb begin
        st_d          = st_q;
        gnt_d         = gnt_q;
        prio_d        = prio_q;
        cnt_d         = cnt_q;
        done_ack      = 1'b0;
        done_err      = 1'b0;
        bif.b_hello_o = 1'b0;
        bif.b_we_o    = 1'b0;
        bif.b_addr_o  = '0;
        bif.b_data_o  = '0;

        unique case (st_q)
            StIdle: begin
                if (bif.m0_hello_i || bif.m1_hello_i) begin
                    // prio breaks the tie only when both request
                    gnt_d = (bif.m0_hello_i && bif.m1_hello_i) ? prio_q : bif.m1_hello_i;
                    cnt_d = '0;
                    st_d  = StBusy;
                end
            end
            StBusy: begin
                bif.b_hello_o = cur_hello;
                bif.b_we_o    = gnt_q ? bif.m1_we_i   : bif.m0_we_i;
                bif.b_addr_o  = gnt_q ? bif.m1_addr_i : bif.m0_addr_i;
                bif.b_data_o  = gnt_q ? bif.m1_data_i : bif.m0_data_i;
                if (bif.b_ack_i) begin
                    done_ack = 1'b1;
                    prio_d   = ~gnt_q;
                    st_d     = StIdle;
                end else if (!cur_hello) begin
                    prio_d = ~gnt_q;
                    st_d   = StIdle;
                end else if (timeout) begin
                    // Withdraw the request so the slave does not complete it after we give up
                    done_ack      = 1'b1;
                    done_err      = 1'b1;
                    bif.b_hello_o = 1'b0;
                    prio_d        = ~gnt_q;
                    st_d          = StIdle;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: st_d = StIdle;
        endcase
    end

    assign bif.m0_ack_o  = done_ack & ~gnt_q;
    assign bif.m1_ack_o  = done_ack &  gnt_q;
    assign bif.m0_err_o  = done_err & ~gnt_q;
    assign bif.m1_err_o  = done_err &  gnt_q;
    assign bif.m0_data_o = bif.b_data_i;
    assign bif.m1_data_o = bif.b_data_i;
endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: per-cycle comparison against a transaction-level model,
// plus hand-computed checks for each scenario.
module tb_bus_arbiter;
    localparam int unsigned TO = 16;

    logic clk = 1'b0;
    logic rst;
    logic ack_auto;
    logic ack_man;
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;

    always #5 clk = ~clk;

    bus_arbiter_if #(.WORDSIZE(16), .ADDRSIZE(16)) bif ();

    // Slave: either acks combinationally on request, or under direct control
    assign bif.b_ack_i = ack_auto ? bif.b_hello_o : ack_man;

    bus_arbiter #(.TIMEOUT(TO), .CNT_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bif (bif)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Transaction-level model: who owns the bus (-1 = nobody) and how long they have held it
    int m_owner = -1;
    int m_pri   = 0;
    int m_held  = 0;
    logic s_rst, s_ack, s_h0, s_h1;
    int   gnt_log[$];
    int   ack_cyc[$];

    always @(negedge clk) begin
        logic [15:0] e_addr, e_data;
        logic        e_we, e_hello, e_ack, e_err, h;
        e_addr = '0; e_data = '0; e_we = 1'b0; e_hello = 1'b0; e_ack = 1'b0; e_err = 1'b0;
        h = 1'b0;
        if (m_owner >= 0) begin
            h       = (m_owner == 0) ? bif.m0_hello_i : bif.m1_hello_i;
            e_addr  = (m_owner == 0) ? bif.m0_addr_i  : bif.m1_addr_i;
            e_data  = (m_owner == 0) ? bif.m0_data_i  : bif.m1_data_i;
            e_we    = (m_owner == 0) ? bif.m0_we_i    : bif.m1_we_i;
            e_hello = h;
            if (bif.b_ack_i) begin
                e_ack = 1'b1;
            end else if (h && (m_held + 1 == TO)) begin
                e_ack   = 1'b1;
                e_err   = 1'b1;
                e_hello = 1'b0;
            end
        end
        chk("b_hello", 32'(bif.b_hello_o), 32'(e_hello));
        chk("b_we",    32'(bif.b_we_o),    32'(e_we));
        chk("b_addr",  32'(bif.b_addr_o),  32'(e_addr));
        chk("b_data",  32'(bif.b_data_o),  32'(e_data));
        chk("m0_ack",  32'(bif.m0_ack_o),  32'(e_ack && m_owner == 0));
        chk("m1_ack",  32'(bif.m1_ack_o),  32'(e_ack && m_owner == 1));
        chk("m0_err",  32'(bif.m0_err_o),  32'(e_err && m_owner == 0));
        chk("m1_err",  32'(bif.m1_err_o),  32'(e_err && m_owner == 1));
        chk("m0_data", 32'(bif.m0_data_o), 32'(bif.b_data_i));
        chk("m1_data", 32'(bif.m1_data_o), 32'(bif.b_data_i));
        if (bif.m0_ack_o) begin gnt_log.push_back(0); ack_cyc.push_back(cyc); end
        if (bif.m1_ack_o) begin gnt_log.push_back(1); ack_cyc.push_back(cyc); end
        s_rst = rst; s_ack = bif.b_ack_i; s_h0 = bif.m0_hello_i; s_h1 = bif.m1_hello_i;
    end

    always @(posedge clk) begin
        cyc++;
        if (s_rst) begin
            m_owner = -1;
            m_pri   = 0;
        end else if (m_owner < 0) begin
            m_held = 0;
            if (s_h0 && s_h1)  m_owner = m_pri;
            else if (s_h0)     m_owner = 0;
            else if (s_h1)     m_owner = 1;
        end else if (s_ack || !((m_owner == 0) ? s_h0 : s_h1) || (m_held + 1 == TO)) begin
            m_pri   = 1 - m_owner;
            m_owner = -1;
        end else begin
            m_held++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; ack_auto = 1'b0; ack_man = 1'b0;
        bif.m0_data_i = 16'h0101; bif.m1_data_i = 16'h0202;
        bif.m0_addr_i = 16'h0004; bif.m1_addr_i = 16'h0020;
        bif.m0_we_i = 1'b0; bif.m1_we_i = 1'b1;
        bif.m0_hello_i = 1'b0; bif.m1_hello_i = 1'b0;
        bif.b_data_i = 16'h0000;
        tick(); tick();
        rst = 1'b0;
        at_neg();
        chk("reset_b_hello", 32'(bif.b_hello_o), 32'd0);
        chk("reset_b_addr", 32'(bif.b_addr_o), 32'd0);
        tick();

        // Single request, slave acks combinationally
        bif.m0_hello_i = 1'b1; bif.b_data_i = 16'hA5A5; ack_auto = 1'b1;
        at_neg();
        chk("single_idle_hello", 32'(bif.b_hello_o), 32'd0);
        tick();
        at_neg();
        chk("single_b_hello", 32'(bif.b_hello_o), 32'd1);
        chk("single_b_addr", 32'(bif.b_addr_o), 32'h0004);
        chk("single_ack", 32'(bif.m0_ack_o), 32'd1);
        chk("single_data", 32'(bif.m0_data_o), 32'hA5A5);
        tick();
        bif.m0_hello_i = 1'b0;
        at_neg();
        chk("single_back_idle", 32'(bif.b_hello_o), 32'd0);
        tick();

        // Contention from reset: grants alternate
        rst = 1'b1; tick(); rst = 1'b0;
        gnt_log.delete(); ack_cyc.delete();
        bif.b_data_i = 16'h1234;
        bif.m0_hello_i = 1'b1; bif.m1_hello_i = 1'b1;
        repeat (8) tick();
        bif.m0_hello_i = 1'b0; bif.m1_hello_i = 1'b0;
        chk("cont_count", 32'(gnt_log.size()), 32'd4);
        if (gnt_log.size() == 4) begin
            chk("cont_g0", 32'(gnt_log[0]), 32'd0);
            chk("cont_g1", 32'(gnt_log[1]), 32'd1);
            chk("cont_g2", 32'(gnt_log[2]), 32'd0);
            chk("cont_g3", 32'(gnt_log[3]), 32'd1);
            for (int i = 1; i < 4; i++) chk("cont_spacing", 32'(ack_cyc[i] - ack_cyc[i-1]), 32'd2);
        end
        tick();

        // Timeout on m1
        ack_auto = 1'b0; ack_man = 1'b0;
        bif.m1_addr_i = 16'h0030; bif.m1_hello_i = 1'b1;
        tick();
        for (int i = 1; i <= 16; i++) begin
            at_neg();
            if (i < 16) begin
                chk("to_busy_hello", 32'(bif.b_hello_o), 32'd1);
                chk("to_busy_noack", 32'(bif.m1_ack_o), 32'd0);
            end else begin
                chk("to_ack", 32'(bif.m1_ack_o), 32'd1);
                chk("to_err", 32'(bif.m1_err_o), 32'd1);
                chk("to_hello_low", 32'(bif.b_hello_o), 32'd0);
            end
            tick();
        end
        bif.m1_hello_i = 1'b0;
        bif.m0_hello_i = 1'b1; bif.m1_hello_i = 1'b1; ack_auto = 1'b1;
        tick();
        at_neg();
        chk("to_prio_m0_addr", 32'(bif.b_addr_o), 32'h0004);
        chk("to_prio_m0_ack", 32'(bif.m0_ack_o), 32'd1);
        tick();
        bif.m0_hello_i = 1'b0; bif.m1_hello_i = 1'b0; ack_auto = 1'b0;
        tick();

        // Ack in the last allowed BUSY cycle
        bif.m0_hello_i = 1'b1; bif.b_data_i = 16'h5A5A;
        tick();
        repeat (15) tick();
        ack_man = 1'b1;
        at_neg();
        chk("last_ack", 32'(bif.m0_ack_o), 32'd1);
        chk("last_err", 32'(bif.m0_err_o), 32'd0);
        chk("last_data", 32'(bif.m0_data_o), 32'h5A5A);
        tick();
        ack_man = 1'b0; bif.m0_hello_i = 1'b0;
        tick();

        // Abort: m0 drops hello in its second BUSY cycle while m1 waits
        bif.m0_hello_i = 1'b1;
        tick();
        bif.m1_hello_i = 1'b1;
        tick();
        bif.m0_hello_i = 1'b0;
        at_neg();
        chk("abort_no_ack", 32'(bif.m0_ack_o), 32'd0);
        chk("abort_hello", 32'(bif.b_hello_o), 32'd0);
        tick();
        at_neg();
        chk("abort_idle", 32'(bif.b_hello_o), 32'd0);
        tick();
        ack_man = 1'b1;
        at_neg();
        chk("abort_m1_addr", 32'(bif.b_addr_o), 32'h0030);
        chk("abort_m1_ack", 32'(bif.m1_ack_o), 32'd1);
        tick();
        ack_man = 1'b0; bif.m1_hello_i = 1'b0;
        tick();

        // Reset in the middle of a transfer
        bif.m1_hello_i = 1'b1;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0; bif.m0_hello_i = 1'b1;
        at_neg();
        chk("rst_b_hello", 32'(bif.b_hello_o), 32'd0);
        chk("rst_b_addr", 32'(bif.b_addr_o), 32'd0);
        chk("rst_no_ack", 32'(bif.m1_ack_o), 32'd0);
        tick();
        ack_man = 1'b1;
        at_neg();
        chk("rst_grant_m0", 32'(bif.b_addr_o), 32'h0004);
        chk("rst_m0_ack", 32'(bif.m0_ack_o), 32'd1);
        tick();
        ack_man = 1'b0; bif.m0_hello_i = 1'b0; bif.m1_hello_i = 1'b0;
        tick(); tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
